// File: rtl/ripple_carry_adder_4bit.sv
// Registered 4-bit ripple-carry adder: a chain of one-bit full-adder stages
// feeding a single output register stage with a one-cycle valid strobe.

module rca_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);
endmodule

module ripple_carry_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_out_valid;

    assign w_c[0] = c_in;

    // Carry ripples stage to stage; bit i waits on carry out of bit i-1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        rca_full_adder u_fa (
            .i_a (a[i]),
            .i_b (b[i]),
            .i_c (w_c[i]),
            .o_s (w_s[i]),
            .o_c (w_c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            // Idle cycles keep the last result visible.
            if (in_valid) begin
                r_sum   <= w_s;
                r_c_out <= w_c[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Self-checking bench: directed corners, hold/reset behaviour, exhaustive sweep
// and random traffic against an arithmetic reference model.

module tb_ripple_carry_adder_4bit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       c_in = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] sum;
    logic       c_out;
    logic       out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: last accepted result and expected valid strobe.
    logic [4:0] m_res = 5'd0;
    logic       m_vld = 1'b0;

    ripple_carry_adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare just after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tb_;
        c_in     = tc;
        @(posedge clk);
        #1;
        if (r) begin
            m_res = 5'd0;
            m_vld = 1'b0;
        end else if (v) begin
            m_res = 5'(int'(ta) + int'(tb_) + int'(tc));
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        chk({tag, "_res"}, 32'({c_out, sum}), 32'(m_res));
        chk({tag, "_vld"}, 32'(out_valid), 32'(m_vld));
    endtask

    initial begin
        step("reset0", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        step("reset1", 1'b1, 1'b1, 4'h7, 4'h3, 1'b1);

        // First accepted input right after reset, no warm-up.
        step("zero",   1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step("carry8", 1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0);
        step("ripple", 1'b0, 1'b1, 4'b1010, 4'b0101, 1'b1);
        step("max31",  1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);

        step("hold_acc", 1'b0, 1'b1, 4'h9, 4'h4, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hold_idle", 1'b0, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom));

        step("pre_rst",  1'b0, 1'b1, 4'h6, 4'h6, 1'b1);
        step("rst_prio", 1'b1, 1'b1, 4'b1111, 4'b0001, 1'b0);
        step("post_rst", 1'b0, 1'b1, 4'h3, 4'h2, 1'b1);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 512; i++)
            step("sweep", 1'b0, 1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8));

        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(0, 19) == 0), 1'($urandom),
                 4'($urandom), 4'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ripple_carry_adder_4bit.md
RIPPLE_CARRY_ADDER_4BIT -- requirements
Module: ripple_carry_adder_4bit

Interface
REQ-001 The block SHALL have one parameter, WIDTH: default 4; operand width; only 4 is required to be supported, and it is kept as a parameter for readability.
REQ-002 The block SHALL have port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst: input, 1 bit, reset, synchronous and active-high.
REQ-004 The block SHALL have port a: input, 4 bits, unsigned operand A.
REQ-005 The block SHALL have port b: input, 4 bits, unsigned operand B.
REQ-006 The block SHALL have port c_in: input, 1 bit, carry into bit 0.
REQ-007 The block SHALL have port in_valid: input, 1 bit; high means a, b and c_in are to be captured this cycle.
REQ-008 The block SHALL have port sum: output, 4 bits, registered sum bits [3:0].
REQ-009 The block SHALL have port c_out: output, 1 bit, registered carry out of bit 3.
REQ-010 The block SHALL have port out_valid: output, 1 bit, registered; high for exactly one cycle per accepted input.

Function
REQ-011 The datapath SHALL be a ripple chain of 4 one-bit full-adder stages: s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]), with c[0] = c_in and c_out = c[4].
REQ-012 Arithmetic SHALL satisfy {c_out, sum} = a + b + c_in as an unsigned 5-bit result, exact for all 512 input combinations, with no saturation.
REQ-013 Latency SHALL be 1 cycle: inputs sampled at rising edge N with in_valid=1 appear on sum/c_out with out_valid=1 after edge N.
REQ-014 When in_valid=0 at an edge, sum and c_out SHALL hold their previous values and out_valid SHALL be 0.
REQ-015 Back-to-back in_valid=1 SHALL be accepted every cycle, giving throughput of one result per cycle with no stall and no backpressure.
REQ-016 Wrap-around: an overflow past 15 SHALL appear only as c_out=1; sum SHALL hold the low 4 bits.
REQ-017 X-free: outputs SHALL never depend on uninitialized state after the first reset.

Reset
REQ-018 While rst=1 at a rising edge, the next state SHALL be sum=4'h0, c_out=0, out_valid=0, regardless of in_valid.
REQ-019 rst SHALL take priority over simultaneous in_valid=1; that input SHALL be discarded.
REQ-020 After rst deasserts, the first accepted input SHALL produce its result one cycle later, with no extra warm-up cycles.

Verification
REQ-021 Zero case: a=0000, b=0000, c_in=0, in_valid=1 SHALL give sum=0000, c_out=0, out_valid=1 one cycle later.
REQ-022 Carry chain without overflow: a=0101 (5), b=0011 (3), c_in=0 SHALL give sum=1000 (8), c_out=0.
REQ-023 Full ripple with c_in: a=1010 (10), b=0101 (5), c_in=1 SHALL give sum=0000, c_out=1 (16).
REQ-024 Maximum inputs: a=1111, b=1111, c_in=1 SHALL give sum=1111, c_out=1 (31).
REQ-025 Hold/valid check: one accepted input followed by 3 cycles of in_valid=0 SHALL give out_valid high for 1 cycle, with sum/c_out unchanged for all 3 idle cycles.
REQ-026 Reset priority: rst=1 together with in_valid=1 and a=1111, b=0001 SHALL give sum=0, c_out=0, out_valid=0 next cycle; an exhaustive 512-combination sweep SHALL match a+b+c_in.
